// File: rtl/conv_accum_controller.sv
// conv_accum_controller: sequences one convolution window into a 32-bit
// signed accumulator. Consumes `taps` sample/coef pairs over valid/ready,
// then holds the sum on a valid/ready output until it is taken.
// Optional macro CONV_ACCUM_SATURATE_EN: clamp on signed overflow instead of wrapping.
module conv_accum_controller #(
   parameter int DATA_W = 16,
   parameter int TAPS_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TAPS_W-1:0] taps,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] coef,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [TAPS_W-1:0] cnt_q, cnt_d;
   logic [31:0]       acc_q, acc_d;
   logic              ovf_q, ovf_d;

   logic              start_acc, pair_acc;
   logic signed [31:0] s_ext, c_ext, prod;
   logic [31:0]       sum;
   logic              add_ovf;

   assign start_acc = (state_q == S_IDLE) && start;
   assign pair_acc  = (state_q == S_ACCUM) && in_valid;

   // Operands are sign-extended to the accumulator width so the product is exact.
   assign s_ext   = 32'($signed(sample));
   assign c_ext   = 32'($signed(coef));
   assign prod    = s_ext * c_ext;
   assign sum     = acc_q + prod;
   // Same-sign addends whose sum flips sign: signed overflow.
   assign add_ovf = (acc_q[31] == prod[31]) && (sum[31] != acc_q[31]);

   // State register; reset aborts any window in flight.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state: a zero-length window skips straight to DONE with a zero result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (taps == '0) ? S_DONE : S_ACCUM;
         S_ACCUM: if (in_valid && cnt_q == TAPS_W'(1)) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded purely from state.
   always_comb begin
      in_ready  = (state_q == S_ACCUM);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
   end

   // Accumulator, remaining count and sticky overflow next-state.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (start_acc) begin
         acc_d = '0;
         cnt_d = taps;
         ovf_d = 1'b0;
      end else if (pair_acc) begin
         cnt_d = cnt_q - TAPS_W'(1);
         ovf_d = ovf_q | add_ovf;
`ifdef CONV_ACCUM_SATURATE_EN
         // Both addends share acc's sign on overflow, so acc's sign picks the rail.
         if (add_ovf) acc_d = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         else         acc_d = sum;
`else
         acc_d = sum;
`endif
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_data = acc_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_conv_accum_controller.sv
// Directed bench for conv_accum_controller with hand-computed expectations.
module tb_conv_accum_controller;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, out_ready;
   logic [4:0]  taps;
   logic [15:0] sample, coef;
   logic        in_ready, out_valid, overflow, busy;
   logic [31:0] out_data;

   int vectors = 0;
   int miscompares = 0;

   conv_accum_controller #(.DATA_W(16), .TAPS_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .taps(taps),
      .in_valid(in_valid), .in_ready(in_ready), .sample(sample), .coef(coef),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; checks and new inputs happen here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one pair for exactly one edge.
   task automatic push(input logic [15:0] s, input logic [15:0] c);
      sample   = s;
      coef     = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] ovf_exp;
`ifdef CONV_ACCUM_SATURATE_EN
      ovf_exp = 32'h7FFF_FFFF;
`else
      ovf_exp = 32'hBFFD_0003;
`endif
      rst = 1'b0; start = 1'b0; taps = '0; in_valid = 1'b0; out_ready = 1'b0;
      sample = '0; coef = '0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b1;
      tick();

      // Basic window: 2*3 + -4*5 + 7*1 = -7
      start = 1'b1; taps = 5'd3;
      tick();
      start = 1'b0;
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_in_ready", 32'(in_ready), 32'd1);
      push(16'sd2, 16'sd3);
      push(-16'sd4, 16'sd5);
      chk("basic_no_early_valid", 32'(out_valid), 32'd0);
      push(16'sd7, 16'sd1);
      chk("basic_out_valid", 32'(out_valid), 32'd1);
      chk("basic_out_data", out_data, 32'hFFFF_FFF9);
      chk("basic_overflow", 32'(overflow), 32'd0);
      chk("basic_done_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("basic_handshake_idle", 32'(busy), 32'd0);
      chk("basic_handshake_valid", 32'(out_valid), 32'd0);

      // Same window with 2-cycle input gaps, then backpressure
      start = 1'b1; taps = 5'd3;
      tick();
      start = 1'b0;
      push(16'sd2, 16'sd3);
      tick(); tick();
      push(-16'sd4, 16'sd5);
      tick(); tick();
      chk("gap_still_accum", 32'(out_valid), 32'd0);
      push(16'sd7, 16'sd1);
      chk("gap_out_data", out_data, 32'hFFFF_FFF9);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin start = 1'b1; taps = 5'd0; end
         tick();
         start = 1'b0;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data", out_data, 32'hFFFF_FFF9);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_idle", 32'(busy), 32'd0);

      // Zero taps: immediate zero result, pairs are not consumed
      start = 1'b1; taps = 5'd0;
      sample = 16'sd9; coef = 16'sd9; in_valid = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_out_valid", 32'(out_valid), 32'd1);
      chk("zero_out_data", out_data, 32'd0);
      chk("zero_overflow", 32'(overflow), 32'd0);
      chk("zero_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("zero_hold_data", out_data, 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("zero_back_idle", 32'(busy), 32'd0);

      // Overflow: 3 * 0x3FFF0001 exceeds the positive range
      start = 1'b1; taps = 5'd3;
      tick();
      start = 1'b0;
      push(16'h7FFF, 16'h7FFF);
      push(16'h7FFF, 16'h7FFF);
      chk("ovf_partial_clear", 32'(overflow), 32'd0);
      push(16'h7FFF, 16'h7FFF);
      chk("ovf_out_data", out_data, ovf_exp);
      chk("ovf_flag", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Back-to-back: start in the IDLE cycle right after the handshake
      start = 1'b1; taps = 5'd1;
      tick();
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_ovf_cleared", 32'(overflow), 32'd0);
      push(16'sd1, 16'sd1);
      chk("b2b_out_data", out_data, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset mid-window after two accepts
      start = 1'b1; taps = 5'd4;
      tick();
      start = 1'b0;
      push(16'sd1, 16'sd1);
      push(16'sd2, 16'sd2);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd0);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out_data", out_data, 32'd0);
      chk("mrst_overflow", 32'(overflow), 32'd0);
      start = 1'b1; taps = 5'd1;
      tick();
      start = 1'b0;
      push(16'sd5, -16'sd6);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_data", out_data, 32'hFFFF_FFE2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_rst_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
